// File: rtl/nibble_serial_adder.sv
// Serial adder that walks operands one nibble per cycle through an external 4-bit adder.
// Optional signed-overflow flag V is built only when OVERFLOW_DETECT_EN is defined.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] X,
  input  logic [4*NIBBLES-1:0] Y,
  input  logic                 Cin,
  output logic [3:0]           A,
  output logic [3:0]           B,
  output logic                 Ci,
  input  logic [3:0]           S,
  input  logic                 Co,
  output logic [4*NIBBLES-1:0] SUM,
  output logic                 Cout,
  output logic                 V,
  output logic                 busy,
  output logic                 done
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state, next_state;
  logic [W-1:0]  x_q, y_q;
  logic          cin_q, carry_q;
  logic [KW-1:0] k;
  logic          accept;
  logic [3:0]    x_nib [NIBBLES];
  logic [3:0]    y_nib [NIBBLES];

  for (genvar i = 0; i < NIBBLES; i++) begin : g_nib
    assign x_nib[i] = x_q[4*i +: 4];
    assign y_nib[i] = y_q[4*i +: 4];
  end

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ADD;
      ADD:     if (k == K_LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The external adder only sees operands while ADD is active; the first nibble takes the latched Cin.
  always_comb begin
    A    = '0;
    B    = '0;
    Ci   = 1'b0;
    busy = (state == ADD);
    done = (state == DONE);
    if (state == ADD) begin
      A  = x_nib[k];
      B  = y_nib[k];
      Ci = (k == '0) ? cin_q : carry_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      k       <= '0;
      SUM     <= '0;
      Cout    <= 1'b0;
    end else if (accept) begin
      x_q     <= X;
      y_q     <= Y;
      cin_q   <= Cin;
      carry_q <= 1'b0;
      k       <= '0;
      SUM     <= '0;
      Cout    <= 1'b0;
    end else if (state == ADD) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (k == KW'(i)) SUM[4*i +: 4] <= S;
      end
      carry_q <= Co;
      // Index parks at 0 after the last nibble instead of wrapping through unused values.
      if (k == K_LAST) begin
        k    <= '0;
        Cout <= Co;
      end else begin
        k <= k + KW'(1);
      end
    end
  end

`ifdef OVERFLOW_DETECT_EN
  // The top result bit is taken from S on the final ADD edge, so V is ready alongside SUM in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      V <= 1'b0;
    end else if (accept) begin
      V <= 1'b0;
    end else if ((state == ADD) && (k == K_LAST)) begin
      V <= (x_q[W-1] == y_q[W-1]) && (S[3] != x_q[W-1]);
    end
  end
`else
  assign V = 1'b0;
`endif

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter NIBBLES, default 4: operand width is 4*NIBBLES bits; legal range 2..8.
REQ-002 Single clock and asynchronous active-low reset; all state changes on rising clk.
REQ-003 clk  input  1  system clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 X  input  4*NIBBLES  operand X.
REQ-007 Y  input  4*NIBBLES  operand Y.
REQ-008 Cin  input  1  carry into nibble 0.
REQ-009 A  output  4  current X nibble to external 4-bit adder.
REQ-010 B  output  4  current Y nibble to external 4-bit adder.
REQ-011 Ci  output  1  carry to external adder.
REQ-012 S  input  4  nibble sum returned by the external adder, combinational in the same cycle.
REQ-013 Co  input  1  carry returned by the external adder.
REQ-014 SUM  output  4*NIBBLES  registered result.
REQ-015 Cout  output  1  registered final carry.
REQ-016 V  output  1  registered signed overflow flag (see Configuration).
REQ-017 busy  output  1  high in ADD state.
REQ-018 done  output  1  one-cycle pulse; result valid.

Function
REQ-019 The FSM SHALL have three states: IDLE, ADD and DONE.
REQ-020 IDLE with start=1 SHALL latch X, Y and Cin, clear nibble index k to 0, and go to ADD.
REQ-021 In ADD, A/B SHALL equal latched X/Y nibble k; Ci SHALL equal latched Cin when k=0, else the carry register.
REQ-022 Each ADD cycle SHALL write S into SUM nibble k, store Co in the carry register, and increment k.
REQ-023 After the ADD cycle with k=NIBBLES-1, the FSM SHALL go to DONE, loading Cout from Co.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 Latency: start sampled at edge 0; busy high for cycles 1..NIBBLES; done high in cycle NIBBLES+1 (cycle 5 for the default).
REQ-026 start SHALL be ignored in ADD and DONE; X, Y and Cin changes after latching SHALL NOT affect the result.
REQ-027 A start held high continuously SHALL begin a new operation in the first IDLE cycle after DONE (back-to-back period NIBBLES+2 cycles).
REQ-028 SUM, Cout and V SHALL hold their values from DONE until the next start is accepted.
REQ-029 SUM, Cout and V SHALL be cleared to 0 on the edge that accepts start.
REQ-030 A, B and Ci SHALL be 0 in IDLE and DONE.
REQ-031 Arithmetic SHALL be unsigned modulo 2^(4*NIBBLES), with the carry-out in Cout; the nibble index SHALL NOT wrap past NIBBLES-1.

Reset
REQ-032 reset_n=0 SHALL immediately force state IDLE, k=0, carry register 0, SUM=0, Cout=0, V=0, busy=0, done=0 and A=B=Ci=0.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-034 Macro OVERFLOW_DETECT_EN defined: in DONE, V SHALL equal (X[msb]==Y[msb]) AND (SUM[msb]!=X[msb]) using the latched operands.
REQ-035 Macro OVERFLOW_DETECT_EN undefined: port V SHALL remain present and tied to 0, and no overflow logic SHALL be generated.

Verification
REQ-036 X=0xFFFF, Y=0x0001, Cin=0 -> SUM=0x0000, Cout=1, done in cycle 5, busy cycles 1-4.
REQ-037 X=0x1234, Y=0x4321, Cin=1 -> SUM=0x5556, Cout=0; A/B sequence 4/1, 3/2, 2/3, 1/4.
REQ-038 Pulse start again at cycle 2 with X=0x0000 -> ignored; result still 0x5556; exactly one done pulse.
REQ-039 Assert reset_n=0 at cycle 3 of 0xFFFF+0x0001 -> all outputs 0 immediately, no done; next start 0x0001+0x0001 -> SUM=0x0002.
REQ-040 X=0x7FFF, Y=0x0001, Cin=0 -> SUM=0x8000, Cout=0; V=1 with OVERFLOW_DETECT_EN, V=0 without.
REQ-041 start held high for 20 cycles -> done pulses at cycles 5, 11 and 17; busy low in each DONE and IDLE cycle.
